prm_edge_mask_engine: RTL and testbench
=======================================

Name: prm_edge_mask_engine

Overview:
- Programmable, time-multiplexed successor to the hard-wired per-edge obstacle logic checkers (one fixed sum-of-products over 15 obstacle bits driving one edge_mask).
- Holds a run-time loaded table of product terms for up to NUM_EDGE roadmap edges and evaluates all of them against one latched occupancy vector, one term per cycle.
- Returns a NUM_EDGE-bit mask vector to the PRM planner front end; bit = 1 means the edge is blocked.

Parameters:
- OCC_W, 15, occupancy vector width (obstacle/voxel bits per check).
- NUM_EDGE, 64, number of edges in the result vector.
- TERM_DEPTH, 1024, term RAM entries.
- EDGE_AW, $clog2(NUM_EDGE), edge-id field width.
- TERM_AW, $clog2(TERM_DEPTH), term address width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- cfg_we  in  1  term write strobe.
- cfg_addr  in  TERM_AW  term RAM address.
- cfg_edge  in  EDGE_AW  edge id the term contributes to.
- cfg_care  in  OCC_W  care mask; 1 = bit participates.
- cfg_val  in  OCC_W  required value on cared bits.
- cfg_cnt_we  in  1  term-count write strobe.
- cfg_cnt  in  TERM_AW+1  number of active terms, 0..TERM_DEPTH.
- cfg_busy  out  1  high outside IDLE; config writes ignored while high.
- req_valid  in  1  check request.
- req_ready  out  1  high only in IDLE.
- req_occ  in  OCC_W  occupancy vector.
- res_valid  out  1  result available.
- res_ready  in  1  result consumed.
- res_mask  out  NUM_EDGE  per-edge blocked flags.
- res_hits  out  TERM_AW+1  matching-term count (see Optional Feature).

Behaviour:
- Reset (rst_n low at posedge): state IDLE, term_cnt=0, res_valid=0, res_mask=0, res_hits=0, cfg_busy=0, req_ready=1 in the cycle after release. Term RAM is not cleared.
- Config: accepted only in IDLE. cfg_we writes {edge, care, val} to cfg_addr. cfg_cnt_we loads term_cnt; values > TERM_DEPTH saturate to TERM_DEPTH. Both strobes may occur in the same cycle.
- Handshake: accept on req_valid & req_ready. req_occ is latched and the accumulator is cleared. The request is not re-sampled until the next IDLE.
- States and transitions:
  - IDLE -> SCAN on accept; if term_cnt=0, IDLE -> DRAIN instead.
  - SCAN issues RAM read address i = 0..term_cnt-1, one per cycle; -> DRAIN after the last issue.
  - DRAIN runs 2 cycles: RAM read stage, then compare stage.
  - DONE -> IDLE on res_ready.
- Compare stage: term i matches iff ((occ ^ val) & care) == 0. On match, acc[edge] is set to 1 and the hit count increments.
- An all-zero care mask always matches. An edge id >= NUM_EDGE never sets a mask bit but still counts as a hit.
- Latency: res_valid rises exactly term_cnt+3 cycles after the accept cycle (3 cycles when term_cnt=0, giving mask 0).
- res_valid, res_mask and res_hits are held stable in DONE until res_ready is high at a posedge. res_valid drops the following cycle and req_ready rises at the same time.
- Simultaneous cfg write and accept in IDLE: the write completes; the scan uses the post-write contents and count.
- Reset mid-SCAN or mid-DONE: aborts with no res_valid pulse. Outputs and state return to reset values; term_cnt returns to 0.
- Accumulator and count width never overflow: hits <= TERM_DEPTH.

Optional Feature:
- Macro PRM_TERM_HIT_CNT_EN.
- Defined: res_hits reports the number of matching terms in the completed scan.
- Undefined: the counter is not instantiated and res_hits is constant 0. All other behaviour and latency are identical.

Test Plan:
- Reset, then request with term_cnt=0 and occ=15'h7FFF -> res_valid 3 cycles after accept; res_mask=0, res_hits=0.
- Load term0 {edge 5, care 15'h0003, val 15'h0001}, term_cnt=1; request occ=15'h0001 -> res_mask bit5=1 only, at accept+4. Repeat with occ=15'h0003 -> mask 0.
- Load 1024 terms, all care=0, edge = i%64, term_cnt=1024 -> all 64 bits set, res_hits=1024, latency 1027 cycles.
- Hold res_ready=0 for 10 cycles after res_valid -> outputs stable and cfg_busy=1; a cfg_we during this window has no effect on a later readback scan.
- Assert rst_n=0 mid-SCAN at term 7 of 20 -> no res_valid; req_ready=1 after release; term_cnt reads 0 (next request done in 3 cycles).
- Term with edge id 70 (NUM_EDGE=64) and care=0 -> res_mask=0; res_hits=1 with PRM_TERM_HIT_CNT_EN, 0 without.

Source files
------------

// File: rtl/prm_edge_mask_engine.sv
// ----------------------------------------------------------------------------
// prm_edge_mask_engine
//
// Purpose:
//   Programmable, time-multiplexed per-edge collision checker for a PRM
//   planner. A run-time loaded table of product terms {edge, care, val} is
//   evaluated one term per cycle against a latched occupancy vector. A term
//   matches when ((occ ^ val) & care) == 0, and a match sets the blocked
//   flag of its edge. An all-zero care mask therefore always matches. An
//   edge id >= NUM_EDGE is counted as a hit but never sets a mask bit.
//
// Ports:
//   clk, rst_n       system clock, synchronous active-low reset
//   cfg_we           term write strobe: {cfg_edge, cfg_care, cfg_val} -> cfg_addr
//   cfg_cnt_we       term-count write strobe (cfg_cnt, saturates at TERM_DEPTH)
//   cfg_busy         high outside IDLE; config strobes are ignored while high
//   req_valid/ready  check request handshake, req_occ = occupancy vector
//   res_valid/ready  result handshake; res_mask / res_hits held while waiting
//
// Build option:
//   PRM_TERM_HIT_CNT_EN  defined   -> res_hits counts matching terms per scan
//                        undefined -> no counter, res_hits is constant 0
//
// Timing: when the accept happens at clock edge P0, the scan ends and
// res_valid is high from edge P(term_cnt+2) onward. Counting the accept cycle
// as cycle 0, that is cycle term_cnt+3.
// ----------------------------------------------------------------------------
module prm_edge_mask_engine #(
  parameter int OCC_W      = 15,
  parameter int NUM_EDGE   = 64,
  parameter int TERM_DEPTH = 1024,
  parameter int EDGE_AW    = $clog2(NUM_EDGE),
  parameter int TERM_AW    = $clog2(TERM_DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_we,
  input  logic [TERM_AW-1:0]  cfg_addr,
  input  logic [EDGE_AW-1:0]  cfg_edge,
  input  logic [OCC_W-1:0]    cfg_care,
  input  logic [OCC_W-1:0]    cfg_val,
  input  logic                cfg_cnt_we,
  input  logic [TERM_AW:0]    cfg_cnt,
  output logic                cfg_busy,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [OCC_W-1:0]    req_occ,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [NUM_EDGE-1:0] res_mask,
  output logic [TERM_AW:0]    res_hits
);

  localparam int ENT_W = EDGE_AW + 2 * OCC_W;
  localparam logic [TERM_AW:0] DEPTH_C = (TERM_AW + 1)'(TERM_DEPTH);
  localparam logic [TERM_AW:0] ONE_C   = (TERM_AW + 1)'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SCAN  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]          r_state;
  logic                r_drain2;   // second DRAIN cycle (compare stage)
  logic [TERM_AW:0]    r_term_cnt;
  logic [TERM_AW:0]    r_idx;      // next term address to issue
  logic [OCC_W-1:0]    r_occ;
  logic [NUM_EDGE-1:0] r_acc;
  logic                r_rd_vld;   // r_ram_q holds a term issued by SCAN
  logic [ENT_W-1:0]    r_ram_q;
  logic [ENT_W-1:0]    r_mem [TERM_DEPTH];

  logic                w_idle;
  logic                w_cfg_we;
  logic                w_cnt_we;
  logic [TERM_AW:0]    w_cnt_sat;
  logic [TERM_AW:0]    w_cnt_eff;
  logic [EDGE_AW-1:0]  w_t_edge;
  logic [OCC_W-1:0]    w_t_care;
  logic [OCC_W-1:0]    w_t_val;
  logic                w_match;
  logic [NUM_EDGE-1:0] w_acc_set;

  assign w_idle    = (r_state == S_IDLE);
  assign w_cfg_we  = cfg_we & w_idle;
  assign w_cnt_we  = cfg_cnt_we & w_idle;
  assign w_cnt_sat = (cfg_cnt > DEPTH_C) ? DEPTH_C : cfg_cnt;
  // A count written in the accept cycle already governs that scan.
  assign w_cnt_eff = w_cnt_we ? w_cnt_sat : r_term_cnt;

  assign w_t_edge = r_ram_q[ENT_W-1 -: EDGE_AW];
  assign w_t_care = r_ram_q[2*OCC_W-1 -: OCC_W];
  assign w_t_val  = r_ram_q[OCC_W-1:0];
  assign w_match  = r_rd_vld && (((r_occ ^ w_t_val) & w_t_care) == '0);

  // Out-of-range edge ids fall through the decode and set nothing.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_acc_set = '0;
    for (int e = 0; e < NUM_EDGE; e++) begin
      if (w_match && (32'(w_t_edge) == e)) w_acc_set[e] = 1'b1;
    end
  end

  // Term RAM with a registered read port. A write in the accept cycle lands
  // before the first read one edge later, so the scan sees post-write data.
  // NOTE: the RAM has no reset; its contents survive rst_n and only the
  // control state is cleared, which keeps it mappable onto block RAM.
  always_ff @(posedge clk) begin
    if (w_cfg_we) r_mem[cfg_addr] <= {cfg_edge, cfg_care, cfg_val};
    r_ram_q <= r_mem[r_idx[TERM_AW-1:0]];
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its peers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_drain2   <= 1'b0;
      r_term_cnt <= '0;
      r_idx      <= '0;
      r_occ      <= '0;
      r_acc      <= '0;
      r_rd_vld   <= 1'b0;
    end else begin
      r_rd_vld <= (r_state == S_SCAN);
      r_acc    <= r_acc | w_acc_set;
      if (w_cnt_we) r_term_cnt <= w_cnt_sat;

      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_occ    <= req_occ;
            r_acc    <= '0;
            r_idx    <= '0;
            r_drain2 <= 1'b0;
            r_state  <= (w_cnt_eff == '0) ? S_DRAIN : S_SCAN;
          end
        end
        S_SCAN: begin
          r_idx <= r_idx + ONE_C;
          // term_cnt is frozen outside IDLE and is non-zero here.
          if (r_idx == r_term_cnt - ONE_C) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          r_drain2 <= 1'b1;
          if (r_drain2) r_state <= S_DONE;
        end
        default: begin  // S_DONE
          if (res_ready) r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef PRM_TERM_HIT_CNT_EN
  logic [TERM_AW:0] r_hits;

  // At most TERM_DEPTH matches per scan, so TERM_AW+1 bits never wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hits <= '0;
    end else if (w_idle && req_valid) begin
      r_hits <= '0;
    end else if (w_match) begin
      r_hits <= r_hits + ONE_C;
    end
  end

  assign res_hits = r_hits;
`else
  assign res_hits = '0;
`endif

  assign cfg_busy  = ~w_idle;
  assign req_ready = w_idle;
  assign res_valid = (r_state == S_DONE);
  assign res_mask  = r_acc;

endmodule

// File: tb/tb_prm_edge_mask_engine.sv
// ----------------------------------------------------------------------------
// tb_prm_edge_mask_engine
//
// Directed bench for prm_edge_mask_engine. The stimulus process pushes the
// expected {mask, hits, latency} of every request into a scoreboard queue. A
// monitor process pops one entry on each rising res_valid and compares it.
// The DUT is built with EDGE_AW=7 so that edge id 70 can be stored.
// ----------------------------------------------------------------------------
module tb_prm_edge_mask_engine;

  localparam int OCC_W      = 15;
  localparam int NUM_EDGE   = 64;
  localparam int TERM_DEPTH = 1024;
  localparam int EDGE_AW    = 7;
  localparam int TERM_AW    = 10;

  typedef struct {
    logic [63:0] mask;
    logic [63:0] hits;
    int          lat;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                cfg_we;
  logic [TERM_AW-1:0]  cfg_addr;
  logic [EDGE_AW-1:0]  cfg_edge;
  logic [OCC_W-1:0]    cfg_care;
  logic [OCC_W-1:0]    cfg_val;
  logic                cfg_cnt_we;
  logic [TERM_AW:0]    cfg_cnt;
  logic                cfg_busy;
  logic                req_valid;
  logic                req_ready;
  logic [OCC_W-1:0]    req_occ;
  logic                res_valid;
  logic                res_ready;
  logic [NUM_EDGE-1:0] res_mask;
  logic [TERM_AW:0]    res_hits;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  prm_edge_mask_engine #(
    .OCC_W(OCC_W), .NUM_EDGE(NUM_EDGE), .TERM_DEPTH(TERM_DEPTH),
    .EDGE_AW(EDGE_AW), .TERM_AW(TERM_AW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_edge(cfg_edge),
    .cfg_care(cfg_care), .cfg_val(cfg_val),
    .cfg_cnt_we(cfg_cnt_we), .cfg_cnt(cfg_cnt), .cfg_busy(cfg_busy),
    .req_valid(req_valid), .req_ready(req_ready), .req_occ(req_occ),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_mask(res_mask), .res_hits(res_hits)
  );

  function automatic logic [63:0] hx(input int n);
`ifdef PRM_TERM_HIT_CNT_EN
    return 64'(n);
`else
    return 64'(n * 0);
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_term(input int addr, input int edge_id,
                            input logic [OCC_W-1:0] care,
                            input logic [OCC_W-1:0] val);
    cfg_we   = 1'b1;
    cfg_addr = TERM_AW'(addr);
    cfg_edge = EDGE_AW'(edge_id);
    cfg_care = care;
    cfg_val  = val;
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic set_cnt(input int n);
    cfg_cnt_we = 1'b1;
    cfg_cnt    = (TERM_AW + 1)'(n);
    tick();
    cfg_cnt_we = 1'b0;
  endtask

  // Wait until the scoreboard is drained and the DUT is back in IDLE.
  task automatic wait_done(input string name);
    for (int i = 0; i < 2000; i++) begin
      if (req_ready && sb.size() == 0) return;
      tick();
    end
    n_cmp++;
    n_fail++;
    $display("FAIL %s_timeout: got no result, expected one within 2000 cycles",
             name);
    sb.delete();
  endtask

  // Request with expectation; any cfg strobes set by the caller are issued in
  // the same cycle as the accept and cleared afterwards.
  task automatic do_req(input string name, input logic [OCC_W-1:0] occ,
                        input logic [63:0] emask, input logic [63:0] ehits,
                        input int elat);
    exp_t e;
    e.mask = emask;
    e.hits = ehits;
    e.lat  = elat;
    sb.push_back(e);
    req_valid  = 1'b1;
    req_occ    = occ;
    tick();
    req_valid  = 1'b0;
    cfg_we     = 1'b0;
    cfg_cnt_we = 1'b0;
    wait_done(name);
  endtask

  // Monitor: samples on the falling edge, timestamps accepts and compares
  // each result against the oldest expectation.
  initial begin : monitor
    int   cyc;
    int   t_acc;
    logic prev_v;
    exp_t e;
    cyc    = 0;
    t_acc  = -1;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        t_acc  = -1;
        prev_v = 1'b0;
      end else begin
        cyc++;
        if (req_valid && req_ready) t_acc = cyc;
        if (res_valid && !prev_v) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_res_valid: got res_valid=1, expected 0");
          end else begin
            e = sb.pop_front();
            check("res_mask", 64'(res_mask), e.mask);
            check("res_hits", 64'(res_hits), e.hits);
            check("latency", 64'(cyc - t_acc), 64'(e.lat));
          end
        end
        prev_v = res_valid;
      end
    end
  end

  initial begin : stim
    logic [63:0] all_ones;
    all_ones   = '1;
    rst_n      = 1'b0;
    cfg_we     = 1'b0;
    cfg_addr   = '0;
    cfg_edge   = '0;
    cfg_care   = '0;
    cfg_val    = '0;
    cfg_cnt_we = 1'b0;
    cfg_cnt    = '0;
    req_valid  = 1'b0;
    req_occ    = '0;
    res_ready  = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Reset state.
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_cfg_busy", 64'(cfg_busy), 64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_res_mask", 64'(res_mask), 64'd0);
    check("rst_res_hits", 64'(res_hits), 64'd0);

    // Empty table: result in 3 cycles with an all-clear mask.
    do_req("empty", 15'h7FFF, 64'd0, 64'd0, 3);

    // Single term on edge 5: bit1..0 must be 01.
    write_term(0, 5, 15'h0003, 15'h0001);
    set_cnt(1);
    do_req("t0_match", 15'h0001, 64'h20, hx(1), 4);
    do_req("t0_miss", 15'h0003, 64'd0, hx(0), 4);

    // Term write, count write and accept in one cycle: scan sees both.
    cfg_we     = 1'b1;
    cfg_addr   = 10'd1;
    cfg_edge   = 7'd9;
    cfg_care   = '0;
    cfg_val    = '0;
    cfg_cnt_we = 1'b1;
    cfg_cnt    = 11'd2;
    do_req("same_cycle_cfg", 15'h0001, 64'h220, hx(2), 5);

    // Full table of always-matching terms, count saturating from 2047.
    for (int i = 0; i < TERM_DEPTH; i++) write_term(i, i % 64, '0, 15'h5A5A);
    set_cnt(2047);
    do_req("full_table", 15'h1234, all_ones, hx(1024), 1027);

    // Result held while res_ready is low; config writes ignored meanwhile.
    write_term(0, 3, 15'h7FFF, 15'h1234);
    set_cnt(1);
    res_ready = 1'b0;
    begin
      exp_t e;
      e.mask = 64'h8;
      e.hits = hx(1);
      e.lat  = 4;
      sb.push_back(e);
    end
    req_valid = 1'b1;
    req_occ   = 15'h1234;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 50 && !res_valid; i++) tick();
    for (int k = 0; k < 10; k++) begin
      check("hold_valid", 64'(res_valid), 64'd1);
      check("hold_mask", 64'(res_mask), 64'h8);
      check("hold_hits", 64'(res_hits), hx(1));
      check("hold_busy", 64'(cfg_busy), 64'd1);
      cfg_we     = (k == 2);
      cfg_addr   = '0;
      cfg_edge   = 7'd10;
      cfg_care   = '0;
      cfg_cnt_we = (k == 2);
      cfg_cnt    = 11'd5;
      tick();
    end
    cfg_we     = 1'b0;
    cfg_cnt_we = 1'b0;
    res_ready  = 1'b1;
    tick();
    check("release_valid", 64'(res_valid), 64'd0);
    check("release_ready", 64'(req_ready), 64'd1);
    do_req("readback", 15'h1234, 64'h8, hx(1), 4);

    // Reset in the middle of a 20-term scan: no result, count cleared.
    set_cnt(20);
    req_valid = 1'b1;
    req_occ   = '0;
    tick();
    req_valid = 1'b0;
    repeat (7) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_req_ready", 64'(req_ready), 64'd1);
    check("abort_cfg_busy", 64'(cfg_busy), 64'd0);
    check("abort_res_valid", 64'(res_valid), 64'd0);
    repeat (30) tick();
    do_req("after_abort", 15'h0000, 64'd0, 64'd0, 3);

    // Edge id beyond NUM_EDGE: counted as a hit, sets no mask bit.
    write_term(0, 70, '0, '0);
    set_cnt(1);
    do_req("edge_oob", 15'h0F0F, 64'd0, hx(1), 4);

    repeat (3) tick();
    if (sb.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL scoreboard_left: got %0d pending, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
